parser_rule_cfg: RTL and testbench



---
 rtl/parser_cfg_pkg.sv | 40 ++++
 rtl/parser_cfg_stage.sv | 151 +++++++++++++++
 rtl/parser_rule_cfg.sv | 207 ++++++++++++++++++++
 tb/tb_parser_rule_cfg.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parser_cfg_pkg.sv
// Shared types for the parser configuration front-end: bus address fields,
// register regions, commit FSM states and the status word layout.
package parser_cfg_pkg;

    typedef enum logic [2:0] {
        REG_OFFSET  = 3'd0,
        REG_TDATA   = 3'd1,
        REG_KEY     = 3'd2,
        REG_HEAD    = 3'd3,
        REG_META    = 3'd4,
        REG_INSTALL = 3'd5,
        REG_COMMIT  = 3'd6,
        REG_STATUS  = 3'd7
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_APPLY = 2'd2
    } commit_state_e;

    localparam int ADDR_STAGE_LSB  = 16;
    localparam int ADDR_STAGE_W    = 4;
    localparam int ADDR_REGION_LSB = 12;
    localparam int ADDR_REGION_W   = 3;
    localparam int ADDR_INDEX_LSB  = 0;
    localparam int ADDR_INDEX_W    = 6;

    // Status word: {err_cnt, epoch of addressed stage, sticky timeout bits}
    function automatic logic [31:0] pack_status(input logic [7:0]  err_cnt,
                                                input logic [7:0]  epoch,
                                                input logic [15:0] timeout);
        return {err_cnt, epoch, timeout};
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parser_cfg_stage.sv
// Per-stage configuration storage: shadow/active type offsets, staged rule
// fields and the rule-install outputs with their single-cycle write pulse.
module parser_cfg_stage
    import parser_cfg_pkg::*;
#(
    parameter int TYPE_NUM          = 4,
    parameter int TYPE_WIDTH        = 16,
    parameter int TYPE_OFFSET_WIDTH = 8,
    parameter int KEY_FIELD_NUM     = 8,
    parameter int KEY_OFFSET_WIDTH  = 6,
    parameter int RULE_NUM          = 16,
    parameter int HEAD_SHIFT_WIDTH  = 6,
    parameter int META_SHIFT_WIDTH  = 6
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst_n,
    input  logic                                            i_wr_en,
    input  region_e                                         i_region,
    input  logic [5:0]                                      i_index,
    input  logic [31:0]                                     i_wdata,
    input  logic                                            i_apply,
    output logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]      o_shadow_offset,
    output logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]             o_stg_type_data,
    output logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]             o_stg_type_mask,
    output logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0]  o_stg_key_offset,
    output logic [HEAD_SHIFT_WIDTH-1:0]                     o_stg_head_shift,
    output logic [META_SHIFT_WIDTH-1:0]                     o_stg_meta_shift,
    output logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]      o_type_offset,
    output logic [RULE_NUM-1:0]                             o_rule_wren,
    output logic                                            o_rule_valid,
    output logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]             o_rule_type_data,
    output logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]             o_rule_type_mask,
    output logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0]  o_rule_key_offset,
    output logic [HEAD_SHIFT_WIDTH-1:0]                     o_rule_head_shift,
    output logic [META_SHIFT_WIDTH-1:0]                     o_rule_meta_shift,
    output logic [7:0]                                      o_epoch
);
    localparam int TI_W = idx_width(TYPE_NUM);
    localparam int KI_W = idx_width(KEY_FIELD_NUM);
    localparam int RI_W = idx_width(RULE_NUM);

    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]     shadow_q, shadow_d, active_q, active_d;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]            stg_tdata_q, stg_tdata_d, stg_tmask_q, stg_tmask_d;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]            rule_tdata_q, rule_tdata_d, rule_tmask_q, rule_tmask_d;
    logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0] stg_key_q, stg_key_d, rule_key_q, rule_key_d;
    logic [HEAD_SHIFT_WIDTH-1:0]                    stg_head_q, stg_head_d, rule_head_q, rule_head_d;
    logic [META_SHIFT_WIDTH-1:0]                    stg_meta_q, stg_meta_d, rule_meta_q, rule_meta_d;
    logic [RULE_NUM-1:0]                            rule_wren_q, rule_wren_d;
    logic                                           rule_valid_q, rule_valid_d;
    logic [7:0]                                     epoch_q, epoch_d;
    logic                                           unused_index;

    assign unused_index = ^i_index;

    always_comb begin
        shadow_d     = shadow_q;
        active_d     = active_q;
        stg_tdata_d  = stg_tdata_q;
        stg_tmask_d  = stg_tmask_q;
        stg_key_d    = stg_key_q;
        stg_head_d   = stg_head_q;
        stg_meta_d   = stg_meta_q;
        rule_tdata_d = rule_tdata_q;
        rule_tmask_d = rule_tmask_q;
        rule_key_d   = rule_key_q;
        rule_head_d  = rule_head_q;
        rule_meta_d  = rule_meta_q;
        rule_valid_d = rule_valid_q;
        rule_wren_d  = '0;
        epoch_d      = epoch_q;
        if (i_wr_en) begin
            case (i_region)
                REG_OFFSET: shadow_d[i_index[TI_W-1:0]] = i_wdata[TYPE_OFFSET_WIDTH-1:0];
                REG_TDATA: begin
                    stg_tdata_d[i_index[TI_W-1:0]] = i_wdata[16 +: TYPE_WIDTH];
                    stg_tmask_d[i_index[TI_W-1:0]] = i_wdata[TYPE_WIDTH-1:0];
                end
                REG_KEY:    stg_key_d[i_index[KI_W-1:0]] = i_wdata[KEY_OFFSET_WIDTH-1:0];
                REG_HEAD:   stg_head_d = i_wdata[HEAD_SHIFT_WIDTH-1:0];
                REG_META:   stg_meta_d = i_wdata[META_SHIFT_WIDTH-1:0];
                REG_INSTALL: begin
                    rule_wren_d[i_index[RI_W-1:0]] = 1'b1;
                    rule_valid_d = i_wdata[0];
                    rule_tdata_d = stg_tdata_q;
                    rule_tmask_d = stg_tmask_q;
                    rule_key_d   = stg_key_q;
                    rule_head_d  = stg_head_q;
                    rule_meta_d  = stg_meta_q;
                end
                default: ;
            endcase
        end
        if (i_apply) begin
            active_d = shadow_q;
            epoch_d  = epoch_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_q     <= '0;
            active_q     <= '0;
            stg_tdata_q  <= '0;
            stg_tmask_q  <= '0;
            stg_key_q    <= '0;
            stg_head_q   <= '0;
            stg_meta_q   <= '0;
            rule_tdata_q <= '0;
            rule_tmask_q <= '0;
            rule_key_q   <= '0;
            rule_head_q  <= '0;
            rule_meta_q  <= '0;
            rule_valid_q <= 1'b0;
            rule_wren_q  <= '0;
            epoch_q      <= '0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            stg_tdata_q  <= stg_tdata_d;
            stg_tmask_q  <= stg_tmask_d;
            stg_key_q    <= stg_key_d;
            stg_head_q   <= stg_head_d;
            stg_meta_q   <= stg_meta_d;
            rule_tdata_q <= rule_tdata_d;
            rule_tmask_q <= rule_tmask_d;
            rule_key_q   <= rule_key_d;
            rule_head_q  <= rule_head_d;
            rule_meta_q  <= rule_meta_d;
            rule_valid_q <= rule_valid_d;
            rule_wren_q  <= rule_wren_d;
            epoch_q      <= epoch_d;
        end
    end

    assign o_shadow_offset   = shadow_q;
    assign o_stg_type_data   = stg_tdata_q;
    assign o_stg_type_mask   = stg_tmask_q;
    assign o_stg_key_offset  = stg_key_q;
    assign o_stg_head_shift  = stg_head_q;
    assign o_stg_meta_shift  = stg_meta_q;
    assign o_type_offset     = active_q;
    assign o_rule_wren       = rule_wren_q;
    assign o_rule_valid      = rule_valid_q;
    assign o_rule_type_data  = rule_tdata_q;
    assign o_rule_type_mask  = rule_tmask_q;
    assign o_rule_key_offset = rule_key_q;
    assign o_rule_head_shift = rule_head_q;
    assign o_rule_meta_shift = rule_meta_q;
    assign o_epoch           = epoch_q;

endmodule

// File: rtl/parser_rule_cfg.sv
// Parser configuration front-end: bus decode, readback, error counting and the
// commit sequencer that moves shadow offsets to active while a stage is idle.
//   state    | meaning
//   ST_IDLE  | no commit pending, bus writes accepted
//   ST_WAIT  | commit latched, waiting for stage idle or timer terminal count
//   ST_APPLY | shadow copied to active, epoch advanced
module parser_rule_cfg
    import parser_cfg_pkg::*;
#(
    parameter int STAGE_NUM         = 3,
    parameter int TYPE_NUM          = 4,
    parameter int TYPE_WIDTH        = 16,
    parameter int TYPE_OFFSET_WIDTH = 8,
    parameter int KEY_FIELD_NUM     = 8,
    parameter int KEY_OFFSET_WIDTH  = 6,
    parameter int RULE_NUM          = 16,
    parameter int HEAD_SHIFT_WIDTH  = 6,
    parameter int META_SHIFT_WIDTH  = 6,
    parameter int COMMIT_TIMEOUT    = 1024
) (
    input  logic                                                          i_clk,
    input  logic                                                          i_rst_n,
    input  logic                                                          i_cfg_wren,
    input  logic                                                          i_cfg_rden,
    input  logic [31:0]                                                   i_cfg_addr,
    input  logic [31:0]                                                   i_cfg_wdata,
    output logic [31:0]                                                   o_cfg_rdata,
    output logic                                                          o_cfg_rvalid,
    output logic                                                          o_cfg_busy,
    input  logic [STAGE_NUM-1:0]                                          i_stage_idle,
    output logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]     o_type_offset,
    output logic [STAGE_NUM-1:0][RULE_NUM-1:0]                            o_rule_wren,
    output logic [STAGE_NUM-1:0]                                          o_rule_valid,
    output logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]            o_rule_type_data,
    output logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]            o_rule_type_mask,
    output logic [STAGE_NUM-1:0][KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0] o_rule_key_offset,
    output logic [STAGE_NUM-1:0][HEAD_SHIFT_WIDTH-1:0]                    o_rule_head_shift,
    output logic [STAGE_NUM-1:0][META_SHIFT_WIDTH-1:0]                    o_rule_meta_shift,
    output logic [STAGE_NUM-1:0][7:0]                                     o_cfg_epoch
);
    localparam int SI_W  = idx_width(STAGE_NUM);
    localparam int TI_W  = idx_width(TYPE_NUM);
    localparam int KI_W  = idx_width(KEY_FIELD_NUM);
    localparam int TMR_W = idx_width(COMMIT_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(COMMIT_TIMEOUT - 1);

    logic [ADDR_STAGE_W-1:0] addr_stage;
    region_e                 addr_region;
    logic [ADDR_INDEX_W-1:0] addr_index;
    logic [SI_W-1:0]         stage_sel;
    int                      idx_lim;
    logic                    stage_ok, idx_ok, busy, wr_ok, wr_err, commit_go, status_rd;
    logic                    unused_addr;
    logic [STAGE_NUM-1:0]    stage_wr, apply;

    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]     shadow_all;
    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]            stg_tdata_all, stg_tmask_all;
    logic [STAGE_NUM-1:0][KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0] stg_key_all;
    logic [STAGE_NUM-1:0][HEAD_SHIFT_WIDTH-1:0]                    stg_head_all;
    logic [STAGE_NUM-1:0][META_SHIFT_WIDTH-1:0]                    stg_meta_all;

    commit_state_e        state_q, state_d;
    logic [SI_W-1:0]      commit_stage_q, commit_stage_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [STAGE_NUM-1:0] timeout_q, timeout_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;

    assign addr_stage  = i_cfg_addr[ADDR_STAGE_LSB +: ADDR_STAGE_W];
    assign addr_region = region_e'(i_cfg_addr[ADDR_REGION_LSB +: ADDR_REGION_W]);
    assign addr_index  = i_cfg_addr[ADDR_INDEX_LSB +: ADDR_INDEX_W];
    assign stage_sel   = addr_stage[SI_W-1:0];
    assign unused_addr = ^{i_cfg_addr[31:20], i_cfg_addr[15], i_cfg_addr[11:6]};

    // Scalar regions (shifts, commit, status) only exist at index 0.
    always_comb begin
        idx_lim = 1;
        case (addr_region)
            REG_OFFSET, REG_TDATA: idx_lim = TYPE_NUM;
            REG_KEY:               idx_lim = KEY_FIELD_NUM;
            REG_INSTALL:           idx_lim = RULE_NUM;
            default:               idx_lim = 1;
        endcase
    end

    assign stage_ok  = 32'(addr_stage) < STAGE_NUM;
    assign idx_ok    = 32'(addr_index) < idx_lim;
    assign busy      = (state_q != ST_IDLE);
    assign wr_ok     = i_cfg_wren && !busy && stage_ok && idx_ok && (addr_region != REG_STATUS);
    assign wr_err    = i_cfg_wren && !wr_ok;
    assign commit_go = wr_ok && (addr_region == REG_COMMIT) && i_cfg_wdata[0];
    assign status_rd = i_cfg_rden && stage_ok && idx_ok && (addr_region == REG_STATUS);

    for (genvar g = 0; g < STAGE_NUM; g++) begin : g_stage
        assign stage_wr[g] = wr_ok && (32'(addr_stage) == g);

        parser_cfg_stage #(
            .TYPE_NUM(TYPE_NUM), .TYPE_WIDTH(TYPE_WIDTH), .TYPE_OFFSET_WIDTH(TYPE_OFFSET_WIDTH),
            .KEY_FIELD_NUM(KEY_FIELD_NUM), .KEY_OFFSET_WIDTH(KEY_OFFSET_WIDTH), .RULE_NUM(RULE_NUM),
            .HEAD_SHIFT_WIDTH(HEAD_SHIFT_WIDTH), .META_SHIFT_WIDTH(META_SHIFT_WIDTH)
        ) u_stage (
            .i_clk            (i_clk),
            .i_rst_n          (i_rst_n),
            .i_wr_en          (stage_wr[g]),
            .i_region         (addr_region),
            .i_index          (addr_index),
            .i_wdata          (i_cfg_wdata),
            .i_apply          (apply[g]),
            .o_shadow_offset  (shadow_all[g]),
            .o_stg_type_data  (stg_tdata_all[g]),
            .o_stg_type_mask  (stg_tmask_all[g]),
            .o_stg_key_offset (stg_key_all[g]),
            .o_stg_head_shift (stg_head_all[g]),
            .o_stg_meta_shift (stg_meta_all[g]),
            .o_type_offset    (o_type_offset[g]),
            .o_rule_wren      (o_rule_wren[g]),
            .o_rule_valid     (o_rule_valid[g]),
            .o_rule_type_data (o_rule_type_data[g]),
            .o_rule_type_mask (o_rule_type_mask[g]),
            .o_rule_key_offset(o_rule_key_offset[g]),
            .o_rule_head_shift(o_rule_head_shift[g]),
            .o_rule_meta_shift(o_rule_meta_shift[g]),
            .o_epoch          (o_cfg_epoch[g])
        );
    end

    // A status read clears the sticky bits first so a timeout in the same cycle survives.
    always_comb begin
        state_d        = state_q;
        commit_stage_d = commit_stage_q;
        timer_d        = timer_q;
        timeout_d      = status_rd ? '0 : timeout_q;
        apply          = '0;
        case (state_q)
            ST_IDLE: begin
                if (commit_go) begin
                    state_d        = ST_WAIT;
                    commit_stage_d = stage_sel;
                    timer_d        = TMR_LOAD;
                end
            end
            ST_WAIT: begin
                if (i_stage_idle[commit_stage_q]) begin
                    state_d = ST_APPLY;
                end else if (timer_q == '0) begin
                    timeout_d[commit_stage_q] = 1'b1;
                    state_d                   = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_APPLY: begin
                apply[commit_stage_q] = 1'b1;
                state_d               = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (wr_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_comb begin
        rvalid_d = i_cfg_rden;
        rdata_d  = '0;
        if (i_cfg_rden && stage_ok && idx_ok) begin
            case (addr_region)
                REG_OFFSET: rdata_d = 32'(shadow_all[stage_sel][addr_index[TI_W-1:0]]);
                REG_TDATA:  rdata_d = {16'(stg_tdata_all[stage_sel][addr_index[TI_W-1:0]]),
                                       16'(stg_tmask_all[stage_sel][addr_index[TI_W-1:0]])};
                REG_KEY:    rdata_d = 32'(stg_key_all[stage_sel][addr_index[KI_W-1:0]]);
                REG_HEAD:   rdata_d = 32'(stg_head_all[stage_sel]);
                REG_META:   rdata_d = 32'(stg_meta_all[stage_sel]);
                REG_STATUS: rdata_d = pack_status(err_cnt_q, o_cfg_epoch[stage_sel], 16'(timeout_q));
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            commit_stage_q <= '0;
            timer_q        <= '0;
            timeout_q      <= '0;
            err_cnt_q      <= '0;
            rdata_q        <= '0;
            rvalid_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            commit_stage_q <= commit_stage_d;
            timer_q        <= timer_d;
            timeout_q      <= timeout_d;
            err_cnt_q      <= err_cnt_d;
            rdata_q        <= rdata_d;
            rvalid_q       <= rvalid_d;
        end
    end

    assign o_cfg_rdata  = rdata_q;
    assign o_cfg_rvalid = rvalid_q;
    assign o_cfg_busy   = busy;

endmodule

// File: tb/tb_parser_rule_cfg.sv
// Self-checking bench for parser_rule_cfg: directed scenarios with a read-return scoreboard.
module tb_parser_rule_cfg;
    localparam int SN = 3, TN = 4, TW = 16, TOW = 8, KN = 8, KOW = 6, RN = 16, HW = 6, MW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_wren = 1'b0, cfg_rden = 1'b0;
    logic [31:0] cfg_addr = '0, cfg_wdata = '0;
    logic [31:0] rdata;
    logic rvalid, busy;
    logic [SN-1:0] stage_idle = '1;
    logic [SN-1:0][TN-1:0][TOW-1:0] type_offset;
    logic [SN-1:0][RN-1:0]          rule_wren;
    logic [SN-1:0]                  rule_valid;
    logic [SN-1:0][TN-1:0][TW-1:0]  rule_tdata, rule_tmask;
    logic [SN-1:0][KN-1:0][KOW-1:0] rule_key;
    logic [SN-1:0][HW-1:0]          rule_head;
    logic [SN-1:0][MW-1:0]          rule_meta;
    logic [SN-1:0][7:0]             epoch;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_addr_q[$];

    always #5 clk = ~clk;

    parser_rule_cfg dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cfg_wren(cfg_wren), .i_cfg_rden(cfg_rden), .i_cfg_addr(cfg_addr), .i_cfg_wdata(cfg_wdata),
        .o_cfg_rdata(rdata), .o_cfg_rvalid(rvalid), .o_cfg_busy(busy),
        .i_stage_idle(stage_idle), .o_type_offset(type_offset),
        .o_rule_wren(rule_wren), .o_rule_valid(rule_valid),
        .o_rule_type_data(rule_tdata), .o_rule_type_mask(rule_tmask),
        .o_rule_key_offset(rule_key), .o_rule_head_shift(rule_head), .o_rule_meta_shift(rule_meta),
        .o_cfg_epoch(epoch)
    );

    function automatic logic [31:0] mk_addr(input logic [3:0] s, input logic [2:0] r, input logic [5:0] i);
        return {12'h000, s, 1'b0, r, 6'h00, i};
    endfunction

    // All tasks start and end at posedge + 1ns.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cfg_addr = a; cfg_wdata = d; cfg_wren = 1'b1;
        @(posedge clk); #1;
        cfg_wren = 1'b0;
    endtask

    task automatic q_read(input logic [31:0] a, input logic [31:0] e);
        rd_addr_q.push_back(a);
        exp_q.push_back(e);
    endtask

    task automatic run_reads(input string tag);
        int n, got, cyc;
        logic [31:0] e;
        n = rd_addr_q.size(); got = 0; cyc = 0;
        while (got < n && cyc < n + 8) begin
            if (rd_addr_q.size() != 0) begin
                cfg_addr = rd_addr_q.pop_front(); cfg_rden = 1'b1;
            end else cfg_rden = 1'b0;
            @(negedge clk);
            if (rvalid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL %s_unexpected_rvalid got=%h", tag, rdata);
                else begin
                    e = exp_q.pop_front();
                    if (rdata !== e) $display("FAIL %s_rd%0d got=%h exp=%h", tag, got, rdata, e);
                    else n_pass++;
                end
                got++;
            end
            @(posedge clk); #1;
        end
        cfg_rden = 1'b0;
        if (got < n) begin
            n_checks++;
            $display("FAIL %s_read_timeout got=%0d exp=%0d", tag, got, n);
            exp_q.delete(); rd_addr_q.delete();
        end
    endtask

    task automatic test_reset();
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (type_offset !== '0) $display("FAIL rst_offset got=%h exp=0", type_offset); else n_pass++;
        n_checks++; if (rule_wren !== '0 || rule_valid !== '0) $display("FAIL rst_rule got=%h/%b exp=0", rule_wren, rule_valid); else n_pass++;
        n_checks++; if (epoch !== '0) $display("FAIL rst_epoch got=%h exp=0", epoch); else n_pass++;
        n_checks++; if (rvalid !== 1'b0) $display("FAIL rst_rvalid got=%b exp=0", rvalid); else n_pass++;
        q_read(mk_addr(0, 7, 0), 32'h0);
        run_reads("rst_status");
    endtask

    task automatic test_shadow_write();
        wr(mk_addr(1, 0, 2), 32'h0000_002A);
        n_checks++; if (type_offset[1][2] !== 8'h00) $display("FAIL shadow_not_active got=%h exp=00", type_offset[1][2]); else n_pass++;
        wr(mk_addr(0, 2, 7), 32'h0000_003F);
        wr(mk_addr(2, 3, 0), 32'hFFFF_FFD5);
        q_read(mk_addr(1, 0, 2), 32'h2A);
        q_read(mk_addr(0, 2, 7), 32'h3F);
        q_read(mk_addr(2, 3, 0), 32'h15);
        q_read(mk_addr(1, 0, 4), 32'h0);
        q_read(mk_addr(3, 0, 0), 32'h0);
        run_reads("shadow");
    endtask

    task automatic test_commit();
        stage_idle = '1;
        wr(mk_addr(1, 6, 0), 32'h1);
        n_checks++; if (busy !== 1'b1) $display("FAIL commit_busy_n1 got=%b exp=1", busy); else n_pass++;
        @(posedge clk); #1;
        stage_idle[1] = 1'b0;
        n_checks++; if (busy !== 1'b1 || type_offset[1][2] !== 8'h00)
            $display("FAIL commit_n2 busy=%b offset=%h exp busy=1 offset=00", busy, type_offset[1][2]); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL commit_busy_n3 got=%b exp=0", busy); else n_pass++;
        n_checks++; if (type_offset[1][2] !== 8'h2A) $display("FAIL commit_offset got=%h exp=2a", type_offset[1][2]); else n_pass++;
        n_checks++; if (epoch[1] !== 8'd1 || epoch[0] !== 8'd0) $display("FAIL commit_epoch got=%h exp=1/0", epoch); else n_pass++;
        stage_idle = '1;
        q_read(mk_addr(1, 7, 0), 32'h0001_0000);
        run_reads("commit_status");
    endtask

    task automatic test_timeout();
        int cnt;
        wr(mk_addr(0, 0, 1), 32'h77);
        stage_idle = '0;
        wr(mk_addr(0, 6, 0), 32'h1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            cnt++;
            @(posedge clk); #1;
        end
        n_checks++; if (cnt != 1024) $display("FAIL timeout_busy_cycles got=%0d exp=1024", cnt); else n_pass++;
        n_checks++; if (type_offset[0] !== '0 || epoch[0] !== 8'd0)
            $display("FAIL timeout_no_apply offset=%h epoch=%h exp=0", type_offset[0], epoch[0]); else n_pass++;
        stage_idle = '1;
        q_read(mk_addr(0, 7, 0), 32'h0000_0001);
        q_read(mk_addr(0, 7, 0), 32'h0000_0000);
        run_reads("timeout_status");
    endtask

    task automatic test_install();
        logic [SN-1:0][RN-1:0] exp_wren;
        wr(mk_addr(2, 1, 0), 32'h0800_FFFF);
        wr(mk_addr(2, 1, 3), 32'h1234_00F0);
        wr(mk_addr(2, 2, 3), 32'h11);
        wr(mk_addr(2, 3, 0), 32'h05);
        wr(mk_addr(2, 4, 0), 32'h22);
        wr(mk_addr(2, 5, 5), 32'h1);
        exp_wren = '0; exp_wren[2][5] = 1'b1;
        n_checks++; if (rule_wren !== exp_wren) $display("FAIL install_wren got=%h exp=%h", rule_wren, exp_wren); else n_pass++;
        n_checks++; if (rule_tdata[2][0] !== 16'h0800 || rule_tmask[2][0] !== 16'hFFFF || rule_tdata[2][3] !== 16'h1234)
            $display("FAIL install_type got=%h/%h/%h exp=0800/ffff/1234", rule_tdata[2][0], rule_tmask[2][0], rule_tdata[2][3]); else n_pass++;
        n_checks++; if (rule_key[2][3] !== 6'h11 || rule_head[2] !== 6'h05 || rule_meta[2] !== 6'h22)
            $display("FAIL install_fields got=%h/%h/%h exp=11/05/22", rule_key[2][3], rule_head[2], rule_meta[2]); else n_pass++;
        n_checks++; if (rule_valid !== 3'b100) $display("FAIL install_valid got=%b exp=100", rule_valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (rule_wren !== '0 || rule_tdata[2][0] !== 16'h0800)
            $display("FAIL install_hold wren=%h data=%h exp=0/0800", rule_wren, rule_tdata[2][0]); else n_pass++;
        wr(mk_addr(2, 5, 3), 32'h0);
        exp_wren = '0; exp_wren[2][3] = 1'b1;
        n_checks++; if (rule_wren !== exp_wren || rule_valid !== 3'b000)
            $display("FAIL install_invalid wren=%h valid=%b exp=%h/000", rule_wren, rule_valid, exp_wren); else n_pass++;
        q_read(mk_addr(2, 1, 0), 32'h0800_FFFF);
        run_reads("install_rb");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  model [TN];
        logic [31:0] d, e;
        logic [7:0]  nv;
        int cnt;
        for (int i = 0; i < TN; i++) begin
            d = $urandom;
            model[i] = d[7:0];
            wr(mk_addr(0, 0, 6'(i)), d);
        end
        for (int i = 0; i < TN; i++) q_read(mk_addr(0, 0, 6'(i)), 32'(model[i]));
        run_reads("b2b");
        nv = model[0] ^ 8'hFF;
        cfg_addr = mk_addr(0, 0, 0); cfg_wdata = 32'(nv); cfg_wren = 1'b1; cfg_rden = 1'b1;
        exp_q.push_back(32'(model[0]));
        @(posedge clk); #1;
        cfg_wren = 1'b0; cfg_rden = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (rvalid !== 1'b1 || rdata !== e) $display("FAIL rw_same_cycle got=%h/%b exp=%h/1", rdata, rvalid, e); else n_pass++;
        model[0] = nv;
        @(posedge clk); #1;
        q_read(mk_addr(0, 0, 0), 32'(nv));
        run_reads("rw_after");
        wr(mk_addr(0, 6, 0), 32'h1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 20) begin cnt++; @(posedge clk); #1; end
        n_checks++; if (cnt != 2) $display("FAIL b2b_commit_busy got=%0d exp=2", cnt); else n_pass++;
        for (int i = 0; i < TN; i++) begin
            n_checks++;
            if (type_offset[0][i] !== model[i]) $display("FAIL b2b_active%0d got=%h exp=%h", i, type_offset[0][i], model[i]);
            else n_pass++;
        end
        n_checks++; if (epoch[0] !== 8'd1) $display("FAIL b2b_epoch got=%h exp=01", epoch[0]); else n_pass++;
    endtask

    task automatic test_errors_reset();
        stage_idle = '0;
        wr(mk_addr(2, 6, 0), 32'h1);
        wr(mk_addr(2, 0, 1), 32'h55);
        wr(mk_addr(15, 0, 0), 32'h66);
        q_read(mk_addr(2, 7, 0), 32'h0200_0000);
        q_read(mk_addr(2, 0, 1), 32'h0);
        run_reads("err");
        n_checks++; if (busy !== 1'b1) $display("FAIL err_still_busy got=%b exp=1", busy); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL wait_rst_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (type_offset !== '0 || epoch !== '0) $display("FAIL wait_rst_state offset=%h epoch=%h exp=0", type_offset, epoch); else n_pass++;
        n_checks++; if (rule_tdata !== '0 || rule_valid !== '0) $display("FAIL wait_rst_rule got=%h/%b exp=0", rule_tdata, rule_valid); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        stage_idle = '1;
        repeat (4) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b0 || epoch[2] !== 8'd0) $display("FAIL wait_rst_abort busy=%b epoch=%h exp=0/00", busy, epoch[2]); else n_pass++;
        q_read(mk_addr(2, 7, 0), 32'h0);
        run_reads("rst_status2");
    endtask

    task automatic test_err_saturate();
        wr(mk_addr(1, 3, 1), 32'h1);
        q_read(mk_addr(1, 7, 0), 32'h0100_0000);
        run_reads("err_idx");
        for (int i = 0; i < 260; i++) wr(mk_addr(0, 7, 0), 32'h1);
        q_read(mk_addr(0, 7, 0), 32'hFF00_0000);
        run_reads("err_sat");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_shadow_write();
        test_commit();
        test_timeout();
        test_install();
        test_back_to_back();
        test_errors_reset();
        test_err_saturate();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
